// File: rtl/user_pulse_seq.sv
// Multi-segment programmable pulse-train generator.
// Plays up to NUM_SEG segments (count, period, high time, polarity) in index
// order, skipping empty segments, optionally looping, with the segment table
// captured into shadow registers when a run is accepted.
module user_pulse_seq #(
    parameter int NUM_SEG = 4,
    parameter int CNT_W   = 8,
    parameter int PER_W   = 16,
    parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       loop_i,
    input  logic [NUM_SEG*CNT_W-1:0]   seg_cnt_i,
    input  logic [NUM_SEG*PER_W-1:0]   seg_period_i,
    input  logic [NUM_SEG*PER_W-1:0]   seg_high_i,
    input  logic [NUM_SEG-1:0]         seg_inv_i,
    output logic                       pulse_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [IDX_W-1:0]           seg_idx_o,
    output logic [CNT_W-1:0]           pulse_idx_o,
    output logic [1:0]                 state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A segment plays only when it has both pulses and a non-zero period.
    function automatic logic [NUM_SEG-1:0] valid_vec(
        input logic [NUM_SEG*CNT_W-1:0] cnt,
        input logic [NUM_SEG*PER_W-1:0] per
    );
        logic [NUM_SEG-1:0] v;
        v = {NUM_SEG{1'b0}};
        for (int k = 0; k < NUM_SEG; k++) begin
            v[k] = (cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b0}}) &&
                   (per[k*PER_W +: PER_W] != {PER_W{1'b0}});
        end
        return v;
    endfunction

    // Lowest set index of a valid vector (0 when none is set).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SEG-1:0] v);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (v[k] && !found) begin
                idx   = IDX_W'(k);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // {found, index} of the first valid segment strictly above cur.
    function automatic logic [IDX_W:0] next_above(
        input logic [NUM_SEG-1:0] v,
        input logic [IDX_W-1:0]   cur
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (v[k] && !found && (k > int'(cur))) begin
                idx   = IDX_W'(k);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Pick the CNT_W-wide field of segment idx.
    function automatic logic [CNT_W-1:0] get_cnt(
        input logic [NUM_SEG*CNT_W-1:0] vec,
        input logic [IDX_W-1:0]         idx
    );
        logic [CNT_W-1:0] r;
        r = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_SEG; k++) begin
            if (IDX_W'(k) == idx) begin
                r = vec[k*CNT_W +: CNT_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Pick the PER_W-wide field of segment idx.
    function automatic logic [PER_W-1:0] get_per(
        input logic [NUM_SEG*PER_W-1:0] vec,
        input logic [IDX_W-1:0]         idx
    );
        logic [PER_W-1:0] r;
        r = {PER_W{1'b0}};
        for (int k = 0; k < NUM_SEG; k++) begin
            if (IDX_W'(k) == idx) begin
                r = vec[k*PER_W +: PER_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           seg_q, seg_d;
    logic [PER_W-1:0]           cyc_q, cyc_d;
    logic [CNT_W-1:0]           pidx_q, pidx_d;
    logic [NUM_SEG*CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [NUM_SEG*PER_W-1:0]   sh_per_q, sh_per_d;
    logic [NUM_SEG*PER_W-1:0]   sh_high_q, sh_high_d;
    logic [NUM_SEG-1:0]         sh_inv_q, sh_inv_d;
    logic                       pulse_q, pulse_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [NUM_SEG-1:0]         vld_in_s;
    logic [NUM_SEG-1:0]         vld_sh_s;
    logic [CNT_W-1:0]           cur_cnt_s;
    logic [PER_W-1:0]           cur_per_s;
    logic [IDX_W:0]             nxt_s;
    logic [PER_W-1:0]           nx_high_s;
    logic                       nx_inv_s;

    // Next-state logic: sequencing, shadow capture and next-cycle output levels.
    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        cyc_d     = cyc_q;
        pidx_d    = pidx_q;
        sh_cnt_d  = sh_cnt_q;
        sh_per_d  = sh_per_q;
        sh_high_d = sh_high_q;
        sh_inv_d  = sh_inv_q;

        vld_in_s  = valid_vec(seg_cnt_i, seg_period_i);
        vld_sh_s  = valid_vec(sh_cnt_q, sh_per_q);
        cur_cnt_s = get_cnt(sh_cnt_q, seg_q);
        cur_per_s = get_per(sh_per_q, seg_q);
        nxt_s     = next_above(vld_sh_s, seg_q);

        case (state_q)
            ST_IDLE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (start_i) begin
                    sh_cnt_d  = seg_cnt_i;
                    sh_per_d  = seg_period_i;
                    sh_high_d = seg_high_i;
                    sh_inv_d  = seg_inv_i;
                    cyc_d     = {PER_W{1'b0}};
                    pidx_d    = {CNT_W{1'b0}};
                    if (|vld_in_s) begin
                        state_d = ST_RUN;
                        seg_d   = lowest_idx(vld_in_s);
                    end else begin
                        state_d = ST_DONE;
                        seg_d   = {IDX_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    seg_d   = {IDX_W{1'b0}};
                    cyc_d   = {PER_W{1'b0}};
                    pidx_d  = {CNT_W{1'b0}};
                end else if (cyc_q == (cur_per_s - PER_W'(1))) begin
                    cyc_d = {PER_W{1'b0}};
                    if (pidx_q == (cur_cnt_s - CNT_W'(1))) begin
                        pidx_d = {CNT_W{1'b0}};
                        if (nxt_s[IDX_W]) begin
                            seg_d = nxt_s[IDX_W-1:0];
                        end else if (loop_i) begin
                            seg_d = lowest_idx(vld_sh_s);
                        end else begin
                            state_d = ST_DONE;
                            seg_d   = {IDX_W{1'b0}};
                        end
                    end else begin
                        pidx_d = pidx_q + CNT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + PER_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                seg_d   = {IDX_W{1'b0}};
                cyc_d   = {PER_W{1'b0}};
                pidx_d  = {CNT_W{1'b0}};
            end
        endcase

        // Output levels are computed from next-state values so they are registered
        // yet still show cyc=0 in the first RUN cycle.
        nx_high_s = get_per(sh_high_d, seg_d);
        nx_inv_s  = 1'b0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (IDX_W'(k) == seg_d) begin
                nx_inv_s = sh_inv_d[k];
            end else begin
                nx_inv_s = nx_inv_s;
            end
        end
        if (state_d == ST_RUN) begin
            pulse_d = (cyc_d < nx_high_s) ^ nx_inv_s;
        end else begin
            pulse_d = 1'b0;
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            seg_q     <= {IDX_W{1'b0}};
            cyc_q     <= {PER_W{1'b0}};
            pidx_q    <= {CNT_W{1'b0}};
            sh_cnt_q  <= {(NUM_SEG*CNT_W){1'b0}};
            sh_per_q  <= {(NUM_SEG*PER_W){1'b0}};
            sh_high_q <= {(NUM_SEG*PER_W){1'b0}};
            sh_inv_q  <= {NUM_SEG{1'b0}};
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            cyc_q     <= cyc_d;
            pidx_q    <= pidx_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_per_q  <= sh_per_d;
            sh_high_q <= sh_high_d;
            sh_inv_q  <= sh_inv_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pulse_o     = pulse_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign seg_idx_o   = seg_q;
    assign pulse_idx_o = pidx_q;
    assign state_o     = state_q;

endmodule
